// File: rtl/ks16_multiword_add_seq_if.sv
// Handshake bundle for ks16_multiword_add_seq: operand request side and result side.
// KS16_SEQ_SIGNED_OVF_EN adds the out_ovf signal.
interface ks16_multiword_add_seq_if #(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef KS16_SEQ_SIGNED_OVF_EN
    logic         out_ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
`ifdef KS16_SEQ_SIGNED_OVF_EN
        , input out_ovf
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
`ifdef KS16_SEQ_SIGNED_OVF_EN
        , output out_ovf
`endif
    );
endinterface

// File: rtl/ks16_multiword_add_seq.sv
// Multi-word adder reusing one 16-bit Kogge-Stone adder, one word per clock, LSW first.
// Optional macro KS16_SEQ_SIGNED_OVF_EN adds a registered two's-complement overflow flag.
module kogge_stone_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] prop;
    logic [15:0] g_cur, p_cur, g_nxt, p_nxt;

    // cin is folded into bit 0's generate so g_cur[i] ends as the carry out of bit i
    always_comb begin
        prop  = a ^ b;
        g_cur = a & b;
        p_cur = prop;
        g_cur[0] = g_cur[0] | (prop[0] & cin);
        g_nxt = '0;
        p_nxt = '0;
        for (int unsigned lvl = 0; lvl < 4; lvl++) begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (i >= (32'd1 << lvl)) begin
                    g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (32'd1 << lvl)]);
                    p_nxt[i] = p_cur[i] & p_cur[i - (32'd1 << lvl)];
                end else begin
                    g_nxt[i] = g_cur[i];
                    p_nxt[i] = p_cur[i];
                end
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        sum  = prop ^ {g_cur[14:0], cin};
        cout = g_cur[15];
    end
endmodule

module ks16_multiword_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    ks16_multiword_add_seq_if.slave   bus,
    output logic                      busy
);
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORDS-1:0][15:0]  a_q, a_d;
    logic [WORDS-1:0][15:0]  b_q, b_d;
    logic [WORDS-1:0][15:0]  sum_q, sum_d;
    logic                    carry_q, carry_d;
    logic                    cout_q, cout_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic [15:0]             add_sum;
    logic                    add_cout;
`ifdef KS16_SEQ_SIGNED_OVF_EN
    logic                    ovf_q, ovf_d;
`endif

    kogge_stone_16 u_add (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef KS16_SEQ_SIGNED_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.in_a;
                    b_d        = bus.in_b;
                    carry_d    = bus.in_cin;
                    idx_d      = '0;
                    state_d    = S_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                sum_d[idx_q] = add_sum;
                carry_d      = add_cout;
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    cout_d      = add_cout;
                    idx_d       = '0;
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
`ifdef KS16_SEQ_SIGNED_OVF_EN
                    // the final word is the most significant one, so its sum MSB is the result sign
                    ovf_d = (a_q[WORDS-1][15] == b_q[WORDS-1][15]) &&
                            (add_sum[15] != a_q[WORDS-1][15]);
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef KS16_SEQ_SIGNED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef KS16_SEQ_SIGNED_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign busy          = busy_q;
`ifdef KS16_SEQ_SIGNED_OVF_EN
    assign bus.out_ovf   = ovf_q;
`endif
endmodule
